// File: rtl/sevenseg_capture.sv
// Seven-segment display snooper: samples a multiplexed anode/cathode bus,
// waits for each pattern to dwell for STABLE_CYCLES samples, then decodes it
// into per-position digit values with frame, error and stall indications.
module sevenseg_capture #(
  parameter int STABLE_CYCLES = 3,
  parameter int STALL_CYCLES  = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] cathodes,
  input  logic [7:0] anodes,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [3:0] digit_valid,
  output logic       frame_done,
  output logic       seg_error,
  output logic       scan_stall
);

  localparam logic [3:0]  STAB_MAX  = 4'(STABLE_CYCLES);
  localparam logic [3:0]  STAB_FIRE = 4'(STABLE_CYCLES - 1);
  localparam logic [15:0] STALL_MAX = 16'(STALL_CYCLES);

  localparam logic [1:0] AN_IDLE = 2'd0;
  localparam logic [1:0] AN_SEL  = 2'd1;
  localparam logic [1:0] AN_ILL  = 2'd2;

  // Active-low segment pattern (g..a) to {legal, value}; blank reads as 4'hF.
  function automatic logic [4:0] seg_decode(input logic [6:0] c);
    logic [4:0] r;
    case (c)
      7'b1000000: r = {1'b1, 4'd0};
      7'b1111001: r = {1'b1, 4'd1};
      7'b0100100: r = {1'b1, 4'd2};
      7'b0110000: r = {1'b1, 4'd3};
      7'b0011001: r = {1'b1, 4'd4};
      7'b0010010: r = {1'b1, 4'd5};
      7'b0000010: r = {1'b1, 4'd6};
      7'b1111000: r = {1'b1, 4'd7};
      7'b0000000: r = {1'b1, 4'd8};
      7'b0010000: r = {1'b1, 4'd9};
      7'b1111111: r = {1'b1, 4'hF};
      default:    r = {1'b0, 4'h0};
    endcase
    return r;
  endfunction

  // Active-low anode pattern to {kind, selected position}.
  function automatic logic [3:0] an_classify(input logic [7:0] a);
    logic [3:0] r;
    case (a)
      8'hFF:   r = {AN_IDLE, 2'd0};
      8'hFE:   r = {AN_SEL,  2'd0};
      8'hFD:   r = {AN_SEL,  2'd1};
      8'hFB:   r = {AN_SEL,  2'd2};
      8'hF7:   r = {AN_SEL,  2'd3};
      default: r = {AN_ILL,  2'd0};
    endcase
    return r;
  endfunction

  logic [7:0]  an_p0, an_p1;
  logic [6:0]  cath_p0, cath_p1;
  logic [3:0]  stab_cnt;
  logic [15:0] stall_cnt;
  logic [3:0]  seen;

  logic        changed;
  logic [3:0]  stab_next;
  logic        fire;
  logic [1:0]  an_kind;
  logic [1:0]  an_idx;
  logic        seg_ok;
  logic [3:0]  seg_val;
  logic        cap_legal;
  logic        cap_undec;
  logic        cap_ill;
  logic [3:0]  cap_onehot;

  // ---- stage p0: pin sample; stage p1: previous sample for the dwell compare
  // Sample the pins and keep the prior sample; reset parks both at inactive.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_p0    <= '1;
      cath_p0  <= '1;
      an_p1    <= '1;
      cath_p1  <= '1;
      stab_cnt <= '0;
    end else begin
      an_p0    <= anodes;
      cath_p0  <= cathodes;
      an_p1    <= an_p0;
      cath_p1  <= cath_p0;
      stab_cnt <= stab_next;
    end
  end

  // Dwell tracking: fire once when the counter lands on STABLE_CYCLES-1.
  // The decode reads the p0 sample, which equals p1 whenever a dwell of more
  // than one sample completes, so a pin change on the capture edge only
  // starts the next dwell.
  always_comb begin
    changed = (an_p0 != an_p1) || (cath_p0 != cath_p1);
    if (changed)
      stab_next = '0;
    else if (stab_cnt < STAB_MAX)
      stab_next = stab_cnt + 4'd1;
    else
      stab_next = stab_cnt;
    fire = (stab_next == STAB_FIRE) && (changed || (stab_cnt != STAB_FIRE));
    {an_kind, an_idx} = an_classify(an_p0);
    {seg_ok, seg_val} = seg_decode(cath_p0);
    cap_legal  = fire && (an_kind == AN_SEL) && seg_ok;
    cap_undec  = fire && (an_kind == AN_SEL) && !seg_ok;
    cap_ill    = fire && (an_kind == AN_ILL);
    cap_onehot = 4'b0001 << an_idx;
  end

  // ---- stage p2: captured results
  // Store the decoded value at the selected position on a legal capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit0 <= '0;
      digit1 <= '0;
      digit2 <= '0;
      digit3 <= '0;
    end else if (cap_legal) begin
      case (an_idx)
        2'd0:    digit0 <= seg_val;
        2'd1:    digit1 <= seg_val;
        2'd2:    digit2 <= seg_val;
        default: digit3 <= seg_val;
      endcase
    end
  end

  // Valid bits follow the most recent capture outcome at each position.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      digit_valid <= '0;
    else if (cap_legal)
      digit_valid <= digit_valid | cap_onehot;
    else if (cap_undec)
      digit_valid <= digit_valid & ~cap_onehot;
  end

  // One-cycle error pulse for an undecodable segment or illegal anode dwell.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      seg_error <= 1'b0;
    else
      seg_error <= cap_undec || cap_ill;
  end

  // Seen mask: a full mask pulses frame_done and restarts the mask, keeping
  // any capture that lands on the restart edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seen       <= '0;
      frame_done <= 1'b0;
    end else if (seen == 4'hF) begin
      seen       <= cap_legal ? cap_onehot : 4'h0;
      frame_done <= 1'b1;
    end else begin
      seen       <= seen | (cap_legal ? cap_onehot : 4'h0);
      frame_done <= 1'b0;
    end
  end

  // Stall counter saturates at the threshold; the flag is registered from it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt  <= '0;
      scan_stall <= 1'b0;
    end else begin
      if (cap_legal)
        stall_cnt <= '0;
      else if (stall_cnt < STALL_MAX)
        stall_cnt <= stall_cnt + 16'd1;
      scan_stall <= (stall_cnt >= STALL_MAX);
    end
  end

endmodule

// File: tb/tb_sevenseg_capture.sv
// Directed bench for sevenseg_capture with default parameters
// (STABLE_CYCLES=3, STALL_CYCLES=50).
module tb_sevenseg_capture;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] cathodes;
  logic [7:0] anodes;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic [3:0] digit_valid;
  logic       frame_done;
  logic       seg_error;
  logic       scan_stall;

  int checks   = 0;
  int failures = 0;
  int fd_cnt   = 0;
  int se_cnt   = 0;

  logic [7:0] an_tab [4];
  logic [6:0] cat_tab [4];

  sevenseg_capture dut (
    .clk         (clk),
    .reset       (reset),
    .cathodes    (cathodes),
    .anodes      (anodes),
    .digit0      (digit0),
    .digit1      (digit1),
    .digit2      (digit2),
    .digit3      (digit3),
    .digit_valid (digit_valid),
    .frame_done  (frame_done),
    .seg_error   (seg_error),
    .scan_stall  (scan_stall)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled on the falling edge.
  always @(negedge clk) begin
    if (frame_done) fd_cnt++;
    if (seg_error)  se_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic scan();
    for (int i = 0; i < 4; i++) begin
      anodes   = an_tab[i];
      cathodes = cat_tab[i];
      tick(5);
    end
  endtask

  initial begin
    an_tab[0] = 8'hFE; cat_tab[0] = 7'b0010010; // 5
    an_tab[1] = 8'hFD; cat_tab[1] = 7'b0011001; // 4
    an_tab[2] = 8'hFB; cat_tab[2] = 7'b0110000; // 3
    an_tab[3] = 8'hF7; cat_tab[3] = 7'b1111001; // 1

    reset    = 1'b0;
    anodes   = 8'hFF;
    cathodes = 7'h7F;
    #1 reset = 1'b1;
    #1;
    chk("rst_digits", 32'({digit3, digit2, digit1, digit0}), 32'h0);
    chk("rst_valid",  32'(digit_valid), 32'h0);
    chk("rst_frame",  32'(frame_done), 32'h0);
    chk("rst_segerr", 32'(seg_error), 32'h0);
    chk("rst_stall",  32'(scan_stall), 32'h0);

    // Dwell: digit 2 at position 0, captured on the 4th edge.
    tick(2);
    reset    = 1'b0;
    anodes   = 8'hFE;
    cathodes = 7'b0100100;
    fd_cnt   = 0;
    se_cnt   = 0;
    tick(3);
    chk("dwell_edge3_valid", 32'(digit_valid), 32'h0);
    tick(1);
    chk("dwell_digit0", 32'(digit0), 32'h2);
    chk("dwell_valid",  32'(digit_valid), 32'h1);
    tick(1);
    chk("dwell_no_err", 32'(se_cnt), 32'h0);

    // Scan 5,4,3,1 twice.
    fd_cnt = 0;
    scan();
    chk("scan1_frame_pulse", 32'(frame_done), 32'h1);
    chk("scan1_digits", 32'({digit3, digit2, digit1, digit0}), 32'h1345);
    chk("scan1_valid",  32'(digit_valid), 32'hF);
    chk("scan1_fd_cnt", 32'(fd_cnt), 32'h0);
    scan();
    anodes   = 8'hFF;
    cathodes = 7'h7F;
    tick(1);
    chk("scan2_frame_low", 32'(frame_done), 32'h0);
    chk("scan2_fd_cnt",    32'(fd_cnt), 32'h2);
    chk("scan_no_err",     32'(se_cnt), 32'h0);
    tick(4);

    // Glitch: digit 8 at position 0 for only 2 samples.
    anodes   = 8'hFE;
    cathodes = 7'b0000000;
    tick(2);
    anodes   = 8'hFF;
    cathodes = 7'h7F;
    tick(6);
    chk("glitch_digits", 32'({digit3, digit2, digit1, digit0}), 32'h1345);
    chk("glitch_valid",  32'(digit_valid), 32'hF);
    chk("glitch_no_err", 32'(se_cnt), 32'h0);
    chk("glitch_no_fd",  32'(fd_cnt), 32'h2);

    // Illegal anode pattern.
    anodes   = 8'hFC;
    cathodes = 7'h7F;
    tick(3);
    chk("ill_an_pre",  32'(seg_error), 32'h0);
    tick(1);
    chk("ill_an_err",  32'(seg_error), 32'h1);
    tick(1);
    chk("ill_an_once", 32'(seg_error), 32'h0);
    chk("ill_an_cnt",  32'(se_cnt), 32'h1);
    chk("ill_an_digits", 32'({digit3, digit2, digit1, digit0}), 32'h1345);
    chk("ill_an_valid",  32'(digit_valid), 32'hF);

    // Undecodable cathode pattern at position 0.
    anodes   = 8'hFE;
    cathodes = 7'b1010101;
    tick(4);
    chk("undec_err",    32'(seg_error), 32'h1);
    chk("undec_valid",  32'(digit_valid), 32'hE);
    chk("undec_digit0", 32'(digit0), 32'h5);
    tick(1);
    chk("undec_cnt",    32'(se_cnt), 32'h2);

    // Blank at position 3.
    anodes   = 8'hF7;
    cathodes = 7'b1111111;
    tick(4);
    chk("blank_digit3", 32'(digit3), 32'hF);
    chk("blank_valid",  32'(digit_valid), 32'hE);

    // Reset in the middle of a digit-7 dwell at position 1.
    anodes   = 8'hFD;
    cathodes = 7'b1111000;
    tick(2);
    #3 reset = 1'b1;
    #1;
    chk("mid_rst_digits", 32'({digit3, digit2, digit1, digit0}), 32'h0);
    chk("mid_rst_valid",  32'(digit_valid), 32'h0);
    chk("mid_rst_err",    32'(seg_error), 32'h0);
    chk("mid_rst_stall",  32'(scan_stall), 32'h0);
    tick(1);
    reset = 1'b0;
    tick(3);
    chk("post_rst_no_early", 32'(digit_valid), 32'h0);
    tick(1);
    chk("post_rst_digit1", 32'(digit1), 32'h7);
    chk("post_rst_valid",  32'(digit_valid), 32'h2);

    // Stall: idle bus for 60 cycles after a fresh reset.
    reset    = 1'b1;
    anodes   = 8'hFF;
    cathodes = 7'h7F;
    #2 reset = 1'b0;
    tick(50);
    chk("stall_c50", 32'(scan_stall), 32'h0);
    tick(1);
    chk("stall_c51", 32'(scan_stall), 32'h1);
    tick(9);
    chk("stall_c60", 32'(scan_stall), 32'h1);
    anodes   = 8'hFE;
    cathodes = 7'b1000000;
    tick(4);
    chk("stall_cap_valid", 32'(digit_valid), 32'h1);
    chk("stall_cap_edge",  32'(scan_stall), 32'h1);
    tick(1);
    chk("stall_cleared",   32'(scan_stall), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sevenseg_capture.md
SEVENSEG_CAPTURE -- requirements
Module: sevenseg_capture

Interface
REQ-001 Parameter STABLE_CYCLES, default 3: consecutive identical samples required before a digit is captured; legal range 1..15.
REQ-002 Parameter STALL_CYCLES, default 50: cycles without any capture before scan_stall asserts; legal range 1..65535.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cathodes  input  7  active-low segments; bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g.
REQ-006 anodes  input  8  active-low digit selects; bits 3..0 select digit3..digit0; bits 7..4 must stay high.
REQ-007 digit0, digit1, digit2, digit3  output  4 each  last captured value per position: 0-9, or 4'hF for blank.
REQ-008 digit_valid  output  4  bit N high when digitN holds a legal capture.
REQ-009 frame_done  output  1  one-cycle pulse when all four positions have been captured since the previous pulse.
REQ-010 seg_error  output  1  one-cycle pulse on an illegal anode or cathode pattern.
REQ-011 scan_stall  output  1  level; high while no capture has occurred for STALL_CYCLES cycles.

Function
REQ-012 cathodes and anodes shall be registered once (sample stage) before any decoding; all timing below counts from the sample register.
REQ-013 Anode classification of the sample:
- idle: no bit low.
- select N: exactly one of bits 3..0 low and bits 7..4 high.
- illegal: any other pattern.
REQ-014 Stability counter:
- Clears to 0 when the sample differs from the previous sample in either anodes or cathodes.
- Otherwise increments, saturating at STABLE_CYCLES.
REQ-015 Capture fires exactly once per dwell, on the edge where the counter reaches STABLE_CYCLES-1, so the pattern has been sampled STABLE_CYCLES consecutive times. The capture is re-armed only after the counter clears.
REQ-016 Capture with select N, by cathode decode (active-low, g..a):
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Blank 1111111 yields 4'hF.
- On a legal decode, digitN and digit_valid[N] are set on the capture edge.
REQ-017 Capture with select N and an undecodable cathode pattern: digitN holds its value, digit_valid[N] clears, seg_error pulses.
REQ-018 Stable illegal anode pattern: seg_error pulses once per dwell; no digit changes. Stable idle: no action.
REQ-019 Seen mask (4 bits):
- Bit N sets on any legal capture at position N.
- When the mask becomes 1111, frame_done pulses on the next cycle and the mask clears in that same cycle.
- Recapturing an already-seen position shall not pulse frame_done.
REQ-020 Stall counter:
- Clears on every legal capture; otherwise increments, saturating.
- scan_stall is high while the counter is >= STALL_CYCLES.
- scan_stall clears on the edge after the next legal capture.
REQ-021 When a capture and a pattern change occur on the same edge, the capture shall use the already-stable value, and the new value starts a fresh dwell.

Reset
REQ-022 Asynchronous reset shall immediately force the following to zero: digit0..digit3, digit_valid, frame_done, seg_error, scan_stall, seen mask, stability counter, stall counter.
REQ-023 Asynchronous reset shall immediately load the sample registers to all-ones (inactive). The first capture after release needs STABLE_CYCLES fresh samples.
REQ-024 Reset asserted mid-dwell shall discard the partial dwell; no capture is completed from pre-reset samples.

Verification
REQ-025 Dwell: anodes=8'hFE, cathodes=7'b0100100 held 5 cycles after reset -> digit0=2, digit_valid=4'b0001 on the 4th edge after the pins change; exactly one capture.
REQ-026 Scan: drive 8'hFE/8'hFD/8'hFB/8'hF7 with digits 5,4,3,1, 5 cycles each -> digit0..3=5,4,3,1, digit_valid=4'hF, one frame_done pulse after the digit3 capture; a second identical scan gives exactly one more pulse.
REQ-027 Glitch: pattern held only 2 cycles (STABLE_CYCLES=3) -> no output change, no seg_error.
REQ-028 Illegal patterns:
- anodes=8'hFC stable -> one seg_error pulse, digits unchanged.
- anodes=8'hFE with cathodes=7'b1010101 -> seg_error, digit_valid[0]=0, digit0 unchanged.
REQ-029 Stall: anodes=8'hFF for 60 cycles -> scan_stall high from cycle 51; next legal capture -> scan_stall low on the following edge.
REQ-030 Blank and reset: anodes=8'hF7 with blank cathodes -> digit3=4'hF, digit_valid[3]=1; reset pulse mid-dwell -> all outputs 0 immediately, no capture from pre-reset samples.
